// File: rtl/fpu_exec_ctrl_if.sv
// fpu_exec_ctrl_if: bundles the upstream issue handshake, the FPU operand and
// result wires and the writeback handshake of the FPU execution controller.
//   master : environment side (decoder, combinational FPU, writeback)
//   slave  : fpu_exec_ctrl side
// Signals:
//   in_valid/in_ready, in_op, in_rs1, in_rs2, in_rd  - op issue
//   flush                                            - kill in-flight op
//   fpu_in1, fpu_in2, fpu_op / fpu_out               - FPU operands / result
//   out_valid/out_ready, out_result, out_rd, out_to_int - writeback
//   busy                                             - controller not idle
`timescale 1ns/1ps
interface fpu_exec_ctrl_if #(
   parameter int BUS_WIDTH = 64,
   parameter int OP_LEN    = 6,
   parameter int RD_W      = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [OP_LEN-1:0]    in_op;
   logic [BUS_WIDTH-1:0] in_rs1;
   logic [BUS_WIDTH-1:0] in_rs2;
   logic [RD_W-1:0]      in_rd;
   logic                 flush;
   logic [BUS_WIDTH-1:0] fpu_in1;
   logic [BUS_WIDTH-1:0] fpu_in2;
   logic [OP_LEN-1:0]    fpu_op;
   logic [BUS_WIDTH-1:0] fpu_out;
   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] out_result;
   logic [RD_W-1:0]      out_rd;
   logic                 out_to_int;
   logic                 busy;

   modport master (
      output in_valid, in_op, in_rs1, in_rs2, in_rd, flush, fpu_out, out_ready,
      input  in_ready, fpu_in1, fpu_in2, fpu_op, out_valid, out_result, out_rd,
             out_to_int, busy
   );

   modport slave (
      input  in_valid, in_op, in_rs1, in_rs2, in_rd, flush, fpu_out, out_ready,
      output in_ready, fpu_in1, fpu_in2, fpu_op, out_valid, out_result, out_rd,
             out_to_int, busy
   );
endinterface

// File: rtl/fpu_exec_ctrl.sv
// fpu_exec_ctrl: sequencing and result-formatting stage around the
// combinational FPU. Accepts one op per handshake, holds the FPU inputs for
// the op latency (LONG_LAT cycles for div/sqrt, 1 otherwise), then captures,
// formats (sign-extend / NaN-box / pass) and presents the result to writeback.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - fpu_exec_ctrl_if.slave (issue, FPU, writeback, flush, busy)
//
// state | meaning
// IDLE  | no op held; ready to accept
// EXEC  | FPU inputs held, counting down the op latency
// DONE  | formatted result presented, waiting for out_ready
`timescale 1ns/1ps
module fpu_exec_ctrl #(
   parameter int BUS_WIDTH = 64,
   parameter int OP_LEN    = 6,
   parameter int RD_W      = 5,
   parameter int LONG_LAT  = 4
) (
   input logic            clk,
   input logic            rst,
   fpu_exec_ctrl_if.slave bus
);
   localparam int CNT_W = (LONG_LAT > 1) ? $clog2(LONG_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_LAT - 1);

   localparam logic [OP_LEN-1:0] OP_DIV_LO = OP_LEN'(6'h06);
   localparam logic [OP_LEN-1:0] OP_DIV_HI = OP_LEN'(6'h09);
   localparam logic [OP_LEN-1:0] OP_CMP_LO = OP_LEN'(6'h14);
   localparam logic [OP_LEN-1:0] OP_CMP_HI = OP_LEN'(6'h19);
   localparam logic [OP_LEN-1:0] OP_MV_X   = OP_LEN'(6'h20);
   localparam logic [OP_LEN-1:0] OP_CVT_LD = OP_LEN'(6'h22);
   localparam logic [OP_LEN-1:0] OP_S_FP_A = OP_LEN'(6'h24);
   localparam logic [OP_LEN-1:0] OP_CVT_WS = OP_LEN'(6'h26);
   localparam logic [OP_LEN-1:0] OP_S_FP_B = OP_LEN'(6'h27);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BUS_WIDTH-1:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d;
   logic [OP_LEN-1:0]    op_q, op_d;
   logic [RD_W-1:0]      rd_q, rd_d;
   logic                 to_int_q, to_int_d;

   logic                 in_ready;
   logic                 accept;
   logic                 op_long;
   logic                 op_to_int;
   logic                 op_sext;
   logic                 op_box;
   logic [BUS_WIDTH-1:0] fmt_res;

   // Formatting is decoded from the held opcode, which is what the FPU is
   // currently computing.
   always_comb begin
      op_to_int = 1'b0;
      op_sext   = 1'b0;
      op_box    = 1'b0;
      case (op_q) inside
         [OP_CMP_LO:OP_CMP_HI]: begin
            op_to_int = 1'b1;
            op_sext   = op_q[0];
         end
         OP_MV_X, OP_CVT_LD: op_to_int = 1'b1;
         OP_CVT_WS: begin
            op_to_int = 1'b1;
            op_sext   = 1'b1;
         end
         OP_S_FP_A, OP_S_FP_B: op_box = 1'b1;
         default: op_box = (op_q < OP_MV_X) && op_q[0];
      endcase

      if (op_sext) begin
         fmt_res = {{(BUS_WIDTH-32){bus.fpu_out[31]}}, bus.fpu_out[31:0]};
      end else if (op_box) begin
         fmt_res = {{(BUS_WIDTH-32){1'b1}}, bus.fpu_out[31:0]};
      end else begin
         fmt_res = bus.fpu_out;
      end
   end

   always_comb begin
      op_long = (bus.in_op >= OP_DIV_LO) && (bus.in_op <= OP_DIV_HI);
      // DONE can take a new op in the same edge its result is consumed.
      in_ready = !bus.flush &&
                 ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
      accept   = bus.in_valid && in_ready;

      state_d  = state_q;
      cnt_d    = cnt_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      op_d     = op_q;
      rd_d     = rd_q;
      res_d    = res_q;
      to_int_d = to_int_q;

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!bus.flush) begin
               res_d    = fmt_res;
               to_int_d = op_to_int;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         in1_d = bus.in_rs1;
         in2_d = bus.in_rs2;
         op_d  = bus.in_op;
         rd_d  = bus.in_rd;
         cnt_d = op_long ? CNT_LONG : '0;
      end

      if (bus.flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         op_q     <= '0;
         rd_q     <= '0;
         res_q    <= '0;
         to_int_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         res_q    <= res_d;
         to_int_q <= to_int_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.fpu_in1    = in1_q;
   assign bus.fpu_in2    = in2_q;
   assign bus.fpu_op     = op_q;
   assign bus.out_valid  = (state_q == DONE);
   assign bus.out_result = res_q;
   assign bus.out_rd     = rd_q;
   assign bus.out_to_int = to_int_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fpu_exec_ctrl.sv
// tb_fpu_exec_ctrl: drives fpu_exec_ctrl with directed and random ops against
// a transaction-level reference model and a behavioural stand-in FPU.
`timescale 1ns/1ps
module tb_fpu_exec_ctrl;
   localparam int BW  = 64;
   localparam int OPL = 6;
   localparam int RDW = 5;
   localparam int LL  = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fpu_exec_ctrl_if #(.BUS_WIDTH(BW), .OP_LEN(OPL), .RD_W(RDW)) bus ();

   fpu_exec_ctrl #(.BUS_WIDTH(BW), .OP_LEN(OPL), .RD_W(RDW), .LONG_LAT(LL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---- behavioural FPU stand-in ----
   function automatic real s2r(input logic [31:0] s);
      logic [10:0] e;
      if (s[30:0] == 31'd0) return 0.0;
      e = {3'b000, s[30:23]} + 11'd896;
      return $bitstoreal({s[31], e, s[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [63:0] fake_fpu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [5:0] op);
      real r;
      logic [31:0] w;
      case (op)
         6'h00: return $realtobits($bitstoreal(a) + $bitstoreal(b));
         6'h06: return $realtobits($bitstoreal(a) / $bitstoreal(b));
         6'h01: return {32'hDEADBEEF, r2s(s2r(a[31:0]) + s2r(b[31:0]))};
         6'h17: return {32'h12345678, 31'd0, (s2r(a[31:0]) < s2r(b[31:0]))};
         6'h26: begin
            r = s2r(a[31:0]);
            if (r > -2147483648.0 && r < 2147483648.0) w = 32'($rtoi(r));
            else w = 32'd0;
            return {32'h0, w};
         end
         default: return a ^ {b[31:0], b[63:32]} ^ {58'd0, op};
      endcase
   endfunction

   assign bus.fpu_out = fake_fpu(bus.fpu_in1, bus.fpu_in2, bus.fpu_op);

   // ---- reference rules ----
   function automatic bit ref_long(input logic [5:0] op);
      return op >= 6 && op <= 9;
   endfunction

   function automatic bit ref_to_int(input logic [5:0] op);
      return (op >= 20 && op <= 25) || op == 32 || op == 34 || op == 38;
   endfunction

   function automatic logic [63:0] ref_format(input logic [5:0] op, input logic [63:0] raw);
      bit single;
      single = (op < 32 && op % 2 == 1) || op == 36 || op == 38 || op == 39;
      if (!single) return raw;
      if (ref_to_int(op)) return {{32{raw[31]}}, raw[31:0]};
      return {32'hFFFFFFFF, raw[31:0]};
   endfunction

   // ---- checking ----
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---- transaction model ----
   bit          m_inflight, m_pending, m_res_int;
   int          m_wait;
   logic [63:0] m_in1, m_in2, m_res;
   logic [5:0]  m_op;
   logic [4:0]  m_rd, m_res_rd;

   task automatic model_reset();
      m_inflight = 0; m_pending = 0; m_res_int = 0; m_wait = 0;
      m_in1 = '0; m_in2 = '0; m_res = '0; m_op = '0; m_rd = '0; m_res_rd = '0;
   endtask

   task automatic step(input bit iv, input logic [5:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input bit fl,
                       input bit ordy);
      bit exp_ready;
      bus.in_valid = iv; bus.in_op = op; bus.in_rs1 = a; bus.in_rs2 = b;
      bus.in_rd = rd; bus.flush = fl; bus.out_ready = ordy;
      #1;
      exp_ready = !fl && !m_inflight && (!m_pending || ordy);
      check("in_ready",  64'(bus.in_ready),  64'(exp_ready));
      check("out_valid", 64'(bus.out_valid), 64'(m_pending));
      check("busy",      64'(bus.busy),      64'(m_inflight || m_pending));
      check("fpu_in1",   bus.fpu_in1,        m_in1);
      check("fpu_in2",   bus.fpu_in2,        m_in2);
      check("fpu_op",    64'(bus.fpu_op),    64'(m_op));
      if (m_pending) begin
         check("out_result", bus.out_result,      m_res);
         check("out_rd",     64'(bus.out_rd),     64'(m_res_rd));
         check("out_to_int", 64'(bus.out_to_int), 64'(m_res_int));
      end
      if (fl) begin
         m_inflight = 0;
         m_pending  = 0;
      end else begin
         if (m_pending && ordy) m_pending = 0;
         if (m_inflight) begin
            if (m_wait == 1) begin
               m_inflight = 0;
               m_pending  = 1;
               m_res      = ref_format(m_op, fake_fpu(m_in1, m_in2, m_op));
               m_res_rd   = m_rd;
               m_res_int  = ref_to_int(m_op);
            end else begin
               m_wait--;
            end
         end
         if (iv && exp_ready) begin
            m_inflight = 1;
            m_wait = ref_long(op) ? LL : 1;
            m_in1 = a; m_in2 = b; m_op = op; m_rd = rd;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      step(0, 6'h3F, 64'h0, 64'h0, 5'd0, 0, ordy);
   endtask

   logic [5:0] pick_ops [14] = '{6'h00, 6'h01, 6'h06, 6'h07, 6'h08, 6'h09, 6'h14,
                                 6'h15, 6'h17, 6'h20, 6'h22, 6'h24, 6'h26, 6'h27};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      logic [5:0] op;
      rst = 1'b1;
      bus.in_valid = 0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
      bus.in_rd = '0; bus.flush = 0; bus.out_ready = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(1);

      // fadd.d
      step(1, 6'h00, 64'h3FF0000000000000, 64'h4000000000000000, 5'd5, 0, 1);
      idle(1);
      check("fadd_d_valid", 64'(bus.out_valid), 64'd1);
      check("fadd_d_res", bus.out_result, 64'h4008000000000000);
      check("fadd_d_rd", 64'(bus.out_rd), 64'd5);
      check("fadd_d_int", 64'(bus.out_to_int), 64'd0);
      idle(1);

      // fadd.s
      step(1, 6'h01, 64'h000000003F800000, 64'h0000000040000000, 5'd6, 0, 1);
      idle(1);
      check("fadd_s_res", bus.out_result, 64'hFFFFFFFF40400000);
      idle(1);

      // fdiv.d: other ops offered while busy must not be taken
      step(1, 6'h06, 64'h4018000000000000, 64'h4008000000000000, 5'd9, 0, 1);
      repeat (3) step(1, 6'h00, 64'h1111, 64'h2222, 5'd1, 0, 1);
      check("fdiv_not_yet", 64'(bus.out_valid), 64'd0);
      check("fdiv_hold", bus.fpu_in1, 64'h4018000000000000);
      step(1, 6'h00, 64'h1111, 64'h2222, 5'd1, 0, 0);
      check("fdiv_valid", 64'(bus.out_valid), 64'd1);
      check("fdiv_res", bus.out_result, 64'h4000000000000000);
      idle(1);

      // flt.s and fcvt.w.s
      step(1, 6'h17, 64'h3F800000, 64'h40000000, 5'd2, 0, 1);
      idle(1);
      check("flt_s_res", bus.out_result, 64'h1);
      check("flt_s_int", 64'(bus.out_to_int), 64'd1);
      idle(1);
      step(1, 6'h26, 64'hBF800000, 64'h0, 5'd3, 0, 1);
      idle(1);
      check("fcvt_w_s_res", bus.out_result, 64'hFFFFFFFFFFFFFFFF);
      check("fcvt_w_s_int", 64'(bus.out_to_int), 64'd1);
      idle(1);

      // backpressure then back-to-back accept
      step(1, 6'h00, 64'h3FF0000000000000, 64'h3FF0000000000000, 5'd3, 0, 0);
      idle(0);
      repeat (3) step(1, 6'h10, 64'hA5A5, 64'h5A5A, 5'd4, 0, 0);
      check("bp_ready_low", 64'(bus.in_ready), 64'd0);
      check("bp_res", bus.out_result, 64'h4000000000000000);
      step(1, 6'h10, 64'hA5A5, 64'h5A5A, 5'd4, 0, 1);
      idle(1);
      check("bp_next_valid", 64'(bus.out_valid), 64'd1);
      check("bp_next_rd", 64'(bus.out_rd), 64'd4);
      idle(1);

      // flush on cycle 2 of a divide
      step(1, 6'h06, 64'h4018000000000000, 64'h4008000000000000, 5'd8, 0, 1);
      idle(1);
      step(0, 6'h00, 64'h0, 64'h0, 5'd0, 1, 1);
      check("flush_idle", 64'(bus.busy), 64'd0);
      seen = 0;
      repeat (6) begin
         idle(1);
         seen |= bus.out_valid;
      end
      check("flush_no_valid", 64'(seen), 64'd0);

      // async reset mid-EXEC
      step(1, 6'h06, 64'h4018000000000000, 64'h4008000000000000, 5'd7, 0, 1);
      bus.in_valid = 0;
      #2 rst = 1'b1;
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_result", bus.out_result, 64'd0);
      check("rst_out_rd", 64'(bus.out_rd), 64'd0);
      check("rst_fpu_in1", bus.fpu_in1, 64'd0);
      check("rst_fpu_in2", bus.fpu_in2, 64'd0);
      check("rst_fpu_op", 64'(bus.fpu_op), 64'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(0, 63));
         else op = pick_ops[$urandom_range(0, 13)];
         step(($urandom % 10) < 7, op, {$urandom, $urandom}, {$urandom, $urandom},
              5'($urandom), ($urandom % 40) == 0, ($urandom % 10) < 6);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
